// File: rtl/byte_serializer_pkg.sv
// Shared types and constants for the byte serializer and its FIFO.
package byte_serializer_pkg;

  localparam int unsigned BYTE_W        = 8;
  localparam int unsigned DEFAULT_DEPTH = 4;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StGap
  } state_e;

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO with occupancy count; DEPTH must be a power of two so the pointers wrap naturally.
module byte_fifo
  import byte_serializer_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic                    pop,
  input  logic [BYTE_W-1:0]       din,
  output logic [BYTE_W-1:0]       dout,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] FullCount = (PtrW + 1)'(DEPTH);

  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]     count_q;
  logic              do_push, do_pop;

  // A full FIFO refuses a write even if a pop frees a slot on the same edge.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign full  = (count_q == FullCount);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/byte_serializer.sv
// Queues bytes in a small FIFO and shifts each out as 8 serial bits followed by a one-cycle gap.
module byte_serializer
  import byte_serializer_pkg::*;
#(
  parameter int unsigned DEPTH     = DEFAULT_DEPTH,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BYTE_W-1:0] in_data,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              frame_start,
  output logic              busy,
  output logic              overflow
);

  logic [$clog2(DEPTH):0] count;
  logic                   full, empty, push, pop;
  logic [BYTE_W-1:0]      fifo_dout;

  state_e            state_q, state_d;
  logic [BYTE_W-1:0] shreg_q, shreg_d;
  logic [2:0]        bitcnt_q, bitcnt_d;
  logic              alive_q, overflow_q;
  logic              ser_out_q, ser_valid_q, frame_start_q;
  logic              next_valid, next_bit;

  // alive_q keeps in_ready low while in reset and until the first edge after release.
  assign in_ready    = alive_q && !full;
  assign push        = in_valid && in_ready;
  assign busy        = (state_q != StIdle) || !empty;
  assign overflow    = overflow_q;
  assign ser_out     = ser_out_q;
  assign ser_valid   = ser_valid_q;
  assign frame_start = frame_start_q;

  byte_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (in_data),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    pop      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (count != '0) begin
          pop      = 1'b1;
          shreg_d  = fifo_dout;
          bitcnt_d = '0;
          state_d  = StShift;
        end
      end
      StShift: begin
        shreg_d  = MSB_FIRST ? {shreg_q[BYTE_W-2:0], 1'b0} : {1'b0, shreg_q[BYTE_W-1:1]};
        bitcnt_d = bitcnt_q + 1'b1;
        if (bitcnt_q == 3'd7) state_d = StGap;
      end
      StGap:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Serial outputs are registered copies of what the next state presents.
  assign next_valid = (state_d == StShift);
  assign next_bit   = MSB_FIRST ? shreg_d[BYTE_W-1] : shreg_d[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      shreg_q       <= '0;
      bitcnt_q      <= '0;
      alive_q       <= 1'b0;
      overflow_q    <= 1'b0;
      ser_out_q     <= 1'b0;
      ser_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      bitcnt_q      <= bitcnt_d;
      alive_q       <= 1'b1;
      if (in_valid && !in_ready) overflow_q <= 1'b1;
      ser_valid_q   <= next_valid;
      ser_out_q     <= next_valid && next_bit;
      frame_start_q <= next_valid && (bitcnt_d == 3'd0);
    end
  end

endmodule

// File: tb/tb_byte_serializer.sv
// Directed scoreboard bench for byte_serializer: one MSB-first and one LSB-first instance.
module tb_byte_serializer;
  import byte_serializer_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       in_valid_m = 1'b0, in_ready_m, ser_out_m, ser_valid_m, frame_start_m;
  logic       busy_m, overflow_m;
  logic [7:0] in_data_m = '0;
  logic       in_valid_l = 1'b0, in_ready_l, ser_out_l, ser_valid_l, frame_start_l;
  logic       busy_l, overflow_l;
  logic [7:0] in_data_l = '0;

  byte_serializer #(.DEPTH(DEPTH), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_m), .in_ready(in_ready_m),
    .in_data(in_data_m), .ser_out(ser_out_m), .ser_valid(ser_valid_m),
    .frame_start(frame_start_m), .busy(busy_m), .overflow(overflow_m)
  );

  byte_serializer #(.DEPTH(DEPTH), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_l), .in_ready(in_ready_l),
    .in_data(in_data_l), .ser_out(ser_out_l), .ser_valid(ser_valid_l),
    .frame_start(frame_start_l), .busy(busy_l), .overflow(overflow_l)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] q_m[$], q_l[$], burst[$];
  int         fs_m[$];
  int         bit_idx_m = 0, bit_idx_l = 0, run_m = 0, run_l = 0;
  logic [7:0] acc_m = '0, acc_l = '0;
  logic       ovf_exp = 1'b0;
  int         first_refuse, last_accept_cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // MSB-first monitor: rebuilds each byte and pops the expected value.
  always @(negedge clk) begin
    if (!rst_n) begin
      bit_idx_m = 0;
      run_m = 0;
    end else begin
      chk("fs_implies_valid_m", !frame_start_m || ser_valid_m, 1);
      chk("count_le_depth_m", int'(dut_m.u_fifo.count) <= DEPTH, 1);
      run_m = ser_valid_m ? run_m + 1 : 0;
      chk("valid_run_le_8_m", run_m <= 8, 1);
      if (ser_valid_m) begin
        chk("frame_start_pos_m", frame_start_m, bit_idx_m == 0);
        if (bit_idx_m == 0) fs_m.push_back(cyc);
        acc_m = {acc_m[6:0], ser_out_m};
        bit_idx_m++;
        if (bit_idx_m == 8) begin
          bit_idx_m = 0;
          if (q_m.size() == 0) chk("unexpected_byte_m", {24'd0, acc_m}, 32'h100);
          else chk("byte_m", acc_m, q_m.pop_front());
        end
      end else begin
        chk("quiet_outputs_m", {ser_out_m, frame_start_m}, 0);
        chk("byte_not_split_m", bit_idx_m, 0);
      end
    end
  end

  // LSB-first monitor.
  always @(negedge clk) begin
    if (!rst_n) begin
      bit_idx_l = 0;
      run_l = 0;
    end else begin
      chk("fs_implies_valid_l", !frame_start_l || ser_valid_l, 1);
      chk("count_le_depth_l", int'(dut_l.u_fifo.count) <= DEPTH, 1);
      run_l = ser_valid_l ? run_l + 1 : 0;
      chk("valid_run_le_8_l", run_l <= 8, 1);
      if (ser_valid_l) begin
        chk("frame_start_pos_l", frame_start_l, bit_idx_l == 0);
        acc_l = {ser_out_l, acc_l[7:1]};
        bit_idx_l++;
        if (bit_idx_l == 8) begin
          bit_idx_l = 0;
          if (q_l.size() == 0) chk("unexpected_byte_l", {24'd0, acc_l}, 32'h100);
          else chk("byte_l", acc_l, q_l.pop_front());
        end
      end else begin
        chk("quiet_outputs_l", {ser_out_l, frame_start_l}, 0);
        chk("byte_not_split_l", bit_idx_l, 0);
      end
    end
  end

  // Offer every byte of burst on consecutive cycles, holding in_valid, tracking overflow.
  task automatic stream_m();
    int idx = 0;
    int n = 0;
    first_refuse = -1;
    while (idx < burst.size() && n < 200) begin
      step();
      chk("overflow_track", overflow_m, ovf_exp);
      in_valid_m = 1'b1;
      in_data_m  = burst[idx];
      if (in_ready_m) begin
        q_m.push_back(burst[idx]);
        last_accept_cyc = cyc;
        idx++;
      end else begin
        ovf_exp = 1'b1;
        if (first_refuse < 0) first_refuse = idx;
      end
      n++;
    end
    chk("stream_timeout", idx, burst.size());
    step();
    in_valid_m = 1'b0;
  endtask

  task automatic send_l(input logic [7:0] d);
    int n = 0;
    step();
    while (!in_ready_l && n < 100) begin step(); n++; end
    chk("send_l_timeout", n < 100, 1);
    in_valid_l = 1'b1;
    in_data_l  = d;
    q_l.push_back(d);
    step();
    in_valid_l = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy_m || busy_l || ser_valid_m || ser_valid_l) && n < 300) begin step(); n++; end
    chk("idle_timeout", n < 300, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset values and first edge after release.
    step();
    step();
    chk("rst_in_ready", in_ready_m, 0);
    chk("rst_busy", busy_m, 0);
    chk("rst_ser_valid", ser_valid_m, 0);
    chk("rst_overflow", overflow_m, 0);
    rst_n = 1'b1;
    #1;
    chk("release_in_ready_pre_edge", in_ready_m, 0);
    step();
    chk("release_in_ready", in_ready_m, 1);
    chk("release_in_ready_l", in_ready_l, 1);

    // MSB-first A5 into an idle block, with first-bit latency.
    fs_m.delete();
    burst = '{8'hA5};
    stream_m();
    wait_idle();
    chk("a5_msb_frames", fs_m.size(), 1);
    if (fs_m.size() == 1) chk("first_bit_latency", fs_m[0], last_accept_cyc + 2);
    chk("a5_msb_drained", q_m.size(), 0);

    // LSB-first A5 then 01.
    send_l(8'hA5);
    send_l(8'h01);
    wait_idle();
    chk("lsb_drained", q_l.size(), 0);

    // Six bytes held valid into a DEPTH=4 FIFO.
    fs_m.delete();
    burst = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
    stream_m();
    chk("first_refused_index", first_refuse, 5);
    chk("overflow_after_refuse", overflow_m, 1);
    wait_idle();
    chk("burst_drained", q_m.size(), 0);
    chk("burst_frames", fs_m.size(), 6);
    for (int i = 1; i < fs_m.size(); i++) chk("byte_spacing", fs_m[i] - fs_m[i-1], 10);

    // Push FF on the same edge as a pop with 3 bytes queued.
    burst = '{8'h20, 8'h21, 8'h22, 8'h23};
    stream_m();
    for (int n = 0; n < 20 && ser_valid_m; n++) step();
    chk("gap_reached", ser_valid_m, 0);
    step();
    chk("count_before_ff", dut_m.u_fifo.count, 3);
    in_valid_m = 1'b1;
    in_data_m  = 8'hFF;
    q_m.push_back(8'hFF);
    step();
    in_valid_m = 1'b0;
    chk("count_push_pop", dut_m.u_fifo.count, 3);
    chk("pop_on_push_edge", frame_start_m, 1);
    wait_idle();
    chk("ff_last_drained", q_m.size(), 0);
    chk("overflow_sticky", overflow_m, 1);

    // Reset mid-byte with two bytes queued.
    burst = '{8'hC3, 8'h31, 8'h32};
    stream_m();
    for (int n = 0; n < 20 && bit_idx_m != 5; n++) step();
    chk("at_bit4", bit_idx_m, 5);
    #2;
    rst_n = 1'b0;
    #1;
    q_m.delete();
    ovf_exp = 1'b0;
    chk("rst_mid_ser_valid", ser_valid_m, 0);
    chk("rst_mid_ser_out", ser_out_m, 0);
    chk("rst_mid_frame_start", frame_start_m, 0);
    chk("rst_mid_busy", busy_m, 0);
    chk("rst_mid_in_ready", in_ready_m, 0);
    chk("rst_mid_overflow", overflow_m, 0);
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_in_ready", in_ready_m, 1);
    for (int n = 0; n < 30; n++) begin
      step();
      chk("post_rst_quiet", {ser_valid_m, busy_m}, 0);
    end

    // A fresh byte after reset still serializes.
    fs_m.delete();
    burst = '{8'h5A};
    stream_m();
    wait_idle();
    chk("post_rst_byte_frames", fs_m.size(), 1);
    chk("post_rst_drained", q_m.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/byte_serializer.md
BYTE_SERIALIZER -- requirements
Module: byte_serializer

Interface
REQ-001 Parameter DEPTH, default 4: byte FIFO depth, power of two, at least 2.
REQ-002 Parameter MSB_FIRST, default 1: 1 shifts bit 7 first; 0 shifts bit 0 first.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 Port in_valid, input, 1: in_data holds a byte to capture.
REQ-006 Port in_ready, output, 1: FIFO can accept a byte this cycle.
REQ-007 Port in_data, input, 8: byte from the upstream register stage (data_out0/data_out1 style outputs).
REQ-008 Port ser_out, output, 1: serial data bit.
REQ-009 Port ser_valid, output, 1: ser_out carries a payload bit.
REQ-010 Port frame_start, output, 1: high only during the first bit of each byte.
REQ-011 Port busy, output, 1: FSM is not IDLE, or the FIFO is not empty.
REQ-012 Port overflow, output, 1: sticky; a byte was offered while the FIFO was full.

Function
REQ-013 The block SHALL write in_data into the FIFO on a rising edge where in_valid and in_ready are both 1.
REQ-014 in_ready SHALL equal (count != DEPTH), with no combinational path from in_valid.
REQ-015 A full FIFO SHALL NOT accept a write, even when a pop occurs in the same cycle.
REQ-016 count SHALL be 0..DEPTH, $clog2(DEPTH)+1 bits wide. Simultaneous push and pop leave count unchanged. Pointers wrap modulo DEPTH.
REQ-017 FSM states SHALL be IDLE, SHIFT and GAP.
REQ-018 In IDLE with count != 0 on an edge, the block SHALL:
- pop the head into the 8-bit shift register;
- clear the bit counter to 0;
- enter SHIFT.
REQ-019 In SHIFT, outputs SHALL be driven as follows:
- ser_valid = 1;
- ser_out = shreg[7] when MSB_FIRST=1, otherwise shreg[0];
- frame_start = 1 only when the bit counter is 0.
REQ-020 In SHIFT, each edge SHALL shift the register one place toward the output end and increment the bit counter; after the edge where the counter equals 7, the FSM enters GAP.
REQ-021 GAP SHALL last exactly one cycle with ser_valid=0 and ser_out=0, then the FSM returns to IDLE.
REQ-022 Per-byte timing SHALL be as follows:
- A byte written into an empty FIFO while in IDLE shows its first bit on the second edge after the write edge.
- Back-to-back bytes occupy 10 cycles each: 8 SHIFT, 1 GAP, 1 IDLE.
REQ-023 Outside SHIFT, ser_valid, ser_out and frame_start SHALL be 0.
REQ-024 overflow SHALL set on any edge with in_valid=1 and in_ready=0, and SHALL clear only on reset.
REQ-025 A push during SHIFT or GAP SHALL only enqueue; it SHALL NOT disturb the byte being shifted.

Reset
REQ-026 On rst_n=0, the following SHALL take effect immediately, independent of clk:
- FSM = IDLE;
- count = 0, read and write pointers = 0;
- shift register = 0, bit counter = 0;
- overflow = 0.
REQ-027 While rst_n=0: in_ready=0, ser_out=0, ser_valid=0, frame_start=0, busy=0.
REQ-028 Reset asserted mid-byte SHALL discard the partial byte and all queued bytes; nothing is resumed after reset.
REQ-029 On the first edge after rst_n rises, in_ready SHALL be 1.

Structure
REQ-030 A shared package SHALL hold:
- the state enum (IDLE, SHIFT, GAP);
- localparam BYTE_W = 8;
- default DEPTH = 4.
REQ-031 The FIFO SHALL be a sub-module byte_fifo with ports:
- push, pop, din, dout, full, empty, count;
- the same clk and rst_n (asynchronous, active-low).
REQ-032 The FSM, shift register and overflow flag SHALL live in byte_serializer.

Verification
REQ-033 Send 8'hA5 with MSB_FIRST=1 into an idle block → ser_out = 1,0,1,0,0,1,0,1 on 8 consecutive cycles, frame_start only on the first, ser_valid then low for 1 cycle.
REQ-034 Send 8'hA5 with MSB_FIRST=0 → ser_out = 1,0,1,0,0,1,0,1 (LSB first). Send 8'h01 → first bit 1, remaining seven bits 0.
REQ-035 Hold in_valid high for 6 bytes 8'h10..8'h15 with DEPTH=4 → in_ready drops when the FIFO fills, no byte is lost, overflow rises at the first refused offer, and the bytes serialize in order at 10-cycle spacing.
REQ-036 Push 8'hFF while the FIFO holds 3 bytes and a pop occurs in the same cycle → count stays 3 and 8'hFF is the last byte shifted.
REQ-037 Assert rst_n=0 during bit 4 of 8'hC3 with 2 bytes queued → outputs drop to 0 immediately, busy=0, and after release no further ser_valid appears until a new byte is pushed.
REQ-038 Check continuously with assertions: frame_start implies ser_valid; count never exceeds DEPTH; ser_valid never stays high for more than 8 consecutive cycles.
